// File: rtl/mnist_pkg.sv
// mnist_pkg: shared constants and types for the MNIST classifier output layer.
//   N_IN      hidden activations per output digit (MAC terms)
//   N_OUT     output digits
//   FRAC_BITS fractional bits of the Q16.16 fixed-point format
//   q16_t     signed Q16.16 data word
//   state_t   layer-2 sequencer FSM states
package mnist_pkg;

  localparam int N_IN      = 32;
  localparam int N_OUT     = 10;
  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] q16_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BIAS_RD = 3'd1,
    S_BIAS_LD = 3'd2,
    S_MAC     = 3'd3,
    S_DRAIN   = 3'd4,
    S_CAPTURE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/argmax_tracker.sv
// argmax_tracker: running maximum of a stream of signed scores.
//   clk, rst   clock, asynchronous active-high reset
//   clear      forget the current maximum (next update always wins)
//   update     offer idx/score as a candidate
//   idx, score candidate index and signed Q16.16 score
//   max_idx    index of the largest score seen since clear
//   max_score  that score
// Only a strictly greater score replaces the maximum, so ties keep the
// earliest (lowest) index.
module argmax_tracker
  import mnist_pkg::*;
#(
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          update,
  input  logic [IW-1:0] idx,
  input  q16_t          score,
  output logic [IW-1:0] max_idx,
  output q16_t          max_score
);

  logic          have_q, have_d;
  logic [IW-1:0] max_idx_q, max_idx_d;
  q16_t          max_score_q, max_score_d;

  always_comb begin
    have_d      = have_q;
    max_idx_d   = max_idx_q;
    max_score_d = max_score_q;
    if (clear) begin
      have_d      = 1'b0;
      max_idx_d   = '0;
      max_score_d = '0;
    end else if (update && (!have_q || (score > max_score_q))) begin
      have_d      = 1'b1;
      max_idx_d   = idx;
      max_score_d = score;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_q      <= 1'b0;
      max_idx_q   <= '0;
      max_score_q <= '0;
    end else begin
      have_q      <= have_d;
      max_idx_q   <= max_idx_d;
      max_score_q <= max_score_d;
    end
  end

  assign max_idx   = max_idx_q;
  assign max_score = max_score_q;

endmodule

// File: rtl/layer2_sequencer.sv
// layer2_sequencer: time-multiplexes one neuron_layer2 MAC over all output
// digits and reports the argmax.
//   clk, rst          clock, asynchronous active-high reset (shared with MAC)
//   start             begin a classification (sampled only in IDLE)
//   busy, done        run in progress / one-cycle result-valid pulse
//   act_addr/rdata    hidden activation buffer (1-cycle read latency)
//   w_addr/rdata      layer-2 weight ROM, address {digit, i}
//   b_addr/rdata      layer-2 bias ROM, address digit
//   mac_*             drive/observe the external MAC
//   score_valid/idx   one pulse per digit with the captured MAC sum in score
//   pred_digit/score  argmax of the run, held until the next accepted start
//   dbg_state         current FSM state
// Control handshake: start is a level sampled only while IDLE; once taken,
// busy stays high through the DONE cycle, and done pulses for exactly one
// cycle when pred_* become valid. start during DONE is ignored.
module layer2_sequencer
  import mnist_pkg::*;
#(
  parameter int N_IN   = mnist_pkg::N_IN,
  parameter int N_OUT  = mnist_pkg::N_OUT,
  parameter int AW_IN  = 5,
  parameter int AW_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [AW_IN-1:0]        act_addr,
  input  q16_t                    act_rdata,
  output logic [AW_OUT+AW_IN-1:0] w_addr,
  input  q16_t                    w_rdata,
  output logic [AW_OUT-1:0]       b_addr,
  input  q16_t                    b_rdata,
  output logic                    mac_bias_load,
  output logic                    mac_valid,
  output q16_t                    mac_value,
  output q16_t                    mac_weight,
  input  q16_t                    mac_sum,
  output logic                    score_valid,
  output logic [AW_OUT-1:0]       score_idx,
  output q16_t                    score,
  output logic [AW_OUT-1:0]       pred_digit,
  output q16_t                    pred_score,
  output state_t                  dbg_state
);

  state_t            state_q, state_d;
  logic [AW_OUT-1:0] j_q, j_d;
  logic [AW_IN-1:0]  act_addr_q, act_addr_d;
  logic              drain_q, drain_d;
  logic              issue_q, issue_d;
  logic              mac_valid_q, mac_valid_d;
  logic              bias_load_q, bias_load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              score_valid_q, score_valid_d;
  logic [AW_OUT-1:0] score_idx_q, score_idx_d;
  q16_t              score_q, score_d;
  logic              am_clear, am_update;

  always_comb begin
    state_d       = state_q;
    j_d           = j_q;
    act_addr_d    = act_addr_q;
    drain_d       = drain_q;
    issue_d       = 1'b0;
    // Read data returns one cycle after the address, so the MAC strobe is
    // the issue strobe delayed by one cycle.
    mac_valid_d   = issue_q;
    bias_load_d   = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    score_valid_d = 1'b0;
    score_idx_d   = score_idx_q;
    score_d       = score_q;
    am_clear      = 1'b0;
    am_update     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_BIAS_RD;
          j_d      = '0;
          busy_d   = 1'b1;
          am_clear = 1'b1;
        end
      end
      S_BIAS_RD: begin
        // b_addr (= j) is presented this cycle; bias data arrives next.
        state_d     = S_BIAS_LD;
        bias_load_d = 1'b1;
      end
      S_BIAS_LD: begin
        state_d    = S_MAC;
        act_addr_d = '0;
        issue_d    = 1'b1;
      end
      S_MAC: begin
        if (act_addr_q == AW_IN'(N_IN - 1)) begin
          state_d    = S_DRAIN;
          act_addr_d = '0;
          drain_d    = 1'b0;
        end else begin
          act_addr_d = act_addr_q + 1'b1;
          issue_d    = 1'b1;
        end
      end
      S_DRAIN: begin
        // First cycle carries the last mac_valid, second lets the MAC's
        // internal accumulate stage settle into mac_sum.
        if (drain_q) begin
          state_d = S_CAPTURE;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        score_valid_d = 1'b1;
        score_idx_d   = j_q;
        score_d       = mac_sum;
        am_update     = 1'b1;
        if (j_q == AW_OUT'(N_OUT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = S_BIAS_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      j_q           <= '0;
      act_addr_q    <= '0;
      drain_q       <= 1'b0;
      issue_q       <= 1'b0;
      mac_valid_q   <= 1'b0;
      bias_load_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      score_valid_q <= 1'b0;
      score_idx_q   <= '0;
      score_q       <= '0;
    end else begin
      state_q       <= state_d;
      j_q           <= j_d;
      act_addr_q    <= act_addr_d;
      drain_q       <= drain_d;
      issue_q       <= issue_d;
      mac_valid_q   <= mac_valid_d;
      bias_load_q   <= bias_load_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      score_valid_q <= score_valid_d;
      score_idx_q   <= score_idx_d;
      score_q       <= score_d;
    end
  end

  argmax_tracker #(
    .IW (AW_OUT)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .clear     (am_clear),
    .update    (am_update),
    .idx       (j_q),
    .score     (mac_sum),
    .max_idx   (pred_digit),
    .max_score (pred_score)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign act_addr      = act_addr_q;
  assign w_addr        = {j_q, act_addr_q};
  assign b_addr        = j_q;
  assign mac_bias_load = bias_load_q;
  assign mac_valid     = mac_valid_q;
  assign mac_value     = bias_load_q ? b_rdata : act_rdata;
  assign mac_weight    = w_rdata;
  assign score_valid   = score_valid_q;
  assign score_idx     = score_idx_q;
  assign score         = score_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_layer2_sequencer.sv
module tb_layer2_sequencer;
  import mnist_pkg::*;

  localparam int AWI    = 5;
  localparam int AWO    = 4;
  localparam int RUN_CY = N_OUT * (N_IN + 5) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic             busy, done;
  logic [AWI-1:0]   act_addr;
  logic [AWO+AWI-1:0] w_addr;
  logic [AWO-1:0]   b_addr;
  q16_t             act_rdata, w_rdata, b_rdata;
  logic             mac_bias_load, mac_valid;
  q16_t             mac_value, mac_weight, mac_sum;
  logic             score_valid;
  logic [AWO-1:0]   score_idx, pred_digit;
  q16_t             score, pred_score;
  state_t           dbg_state;

  layer2_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .act_addr      (act_addr),
    .act_rdata     (act_rdata),
    .w_addr        (w_addr),
    .w_rdata       (w_rdata),
    .b_addr        (b_addr),
    .b_rdata       (b_rdata),
    .mac_bias_load (mac_bias_load),
    .mac_valid     (mac_valid),
    .mac_value     (mac_value),
    .mac_weight    (mac_weight),
    .mac_sum       (mac_sum),
    .score_valid   (score_valid),
    .score_idx     (score_idx),
    .score         (score),
    .pred_digit    (pred_digit),
    .pred_score    (pred_score),
    .dbg_state     (dbg_state)
  );

  // ---------------- memories (1-cycle synchronous read) ----------------
  q16_t act_mem [N_IN];
  q16_t w_mem   [N_OUT*N_IN];
  q16_t b_mem   [N_OUT];

  always @(posedge clk) begin
    act_rdata <= act_mem[act_addr];
    w_rdata   <= w_mem[w_addr];
    b_rdata   <= b_mem[b_addr];
  end

  function automatic q16_t mul_q(input q16_t a, input q16_t b);
    logic signed [63:0] ax, bx, p;
    ax = a;
    bx = b;
    p  = ax * bx;
    return q16_t'(p >>> FRAC_BITS);
  endfunction

  // ---------------- MAC model: product stage then accumulate stage ----------------
  q16_t mac_acc, mac_prod;
  logic mac_v2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_acc  <= '0;
      mac_prod <= '0;
      mac_v2   <= 1'b0;
    end else begin
      mac_v2 <= mac_valid;
      if (mac_valid) mac_prod <= mul_q(mac_value, mac_weight);
      if (mac_bias_load) mac_acc <= mac_value;
      else if (mac_v2) mac_acc <= mac_acc + mac_prod;
    end
  end
  assign mac_sum = mac_acc;

  // ---------------- checking ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [AWO+31:0] exp_q[$];
  logic [AWO-1:0]  exp_pred_digit;
  q16_t            exp_pred_score;

  task automatic push_expected();
    q16_t s, bs;
    logic [AWO-1:0] bi;
    bs = '0;
    bi = '0;
    for (int j = 0; j < N_OUT; j++) begin
      s = b_mem[j];
      for (int i = 0; i < N_IN; i++) s = s + mul_q(act_mem[i], w_mem[j*N_IN+i]);
      exp_q.push_back({AWO'(j), s});
      if (j == 0 || s > bs) begin
        bs = s;
        bi = AWO'(j);
      end
    end
    exp_pred_digit = bi;
    exp_pred_score = bs;
  endtask

  int tick     = 0;
  int last_sv  = 0;
  int done_cnt = 0;
  int overlap  = 0;

  initial forever begin
    @(posedge clk);
    tick++;
  end

  initial forever begin
    logic [AWO+31:0] e;
    q16_t es;
    @(negedge clk);
    if (score_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        es = e[31:0];
        check("score", score, es);
        check("score_idx", score_idx, e[AWO+31:32]);
      end
      if (score_idx != 0) check("sv_spacing", tick - last_sv, N_IN + 5);
      last_sv = tick;
    end
    if (done) done_cnt++;
    if (mac_bias_load && mac_valid) overlap++;
  end

  // ---------------- driver tasks ----------------
  task automatic load_case(input int kind);
    for (int i = 0; i < N_IN; i++) act_mem[i] = 32'h0001_0000;
    for (int j = 0; j < N_OUT; j++) begin
      b_mem[j] = '0;
      for (int i = 0; i < N_IN; i++) w_mem[j*N_IN+i] = '0;
    end
    case (kind)
      0: for (int j = 0; j < N_OUT; j++) b_mem[j] = q16_t'(j <<< FRAC_BITS);
      1: for (int i = 0; i < N_IN; i++) w_mem[3*N_IN+i] = 32'h0000_8000;
      2: for (int i = 0; i < N_IN; i++) act_mem[i] = '0;
      3: for (int j = 0; j < N_OUT; j++) b_mem[j] = q16_t'(-(5 + j) <<< FRAC_BITS);
      default: begin
        for (int i = 0; i < N_IN; i++)
          act_mem[i] = q16_t'($urandom_range(32'h0003_0000, 0)) - 32'sh0001_8000;
        for (int j = 0; j < N_OUT; j++) begin
          b_mem[j] = q16_t'($urandom_range(32'h0008_0000, 0)) - 32'sh0004_0000;
          for (int i = 0; i < N_IN; i++)
            w_mem[j*N_IN+i] = q16_t'($urandom_range(32'h0002_0000, 0)) - 32'sh0001_0000;
        end
      end
    endcase
  endtask

  // Called in cycle 1 of a run (first negedge after the accepting edge);
  // returns the cycle number on which done was seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < RUN_CY + 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_act_addr"}, act_addr, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_b_addr"}, b_addr, 0);
    check({tag, "_bias_load"}, mac_bias_load, 0);
    check({tag, "_mac_valid"}, mac_valid, 0);
    check({tag, "_score_valid"}, score_valid, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_score_idx"}, score_idx, 0);
    check({tag, "_pred_digit"}, pred_digit, 0);
    check({tag, "_pred_score"}, pred_score, 0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  task automatic run_case(input string tag, input int kind);
    int cyc, d0;
    load_case(kind);
    push_expected();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_pred_clr"}, pred_digit, 0);
    wait_done(cyc);
    check({tag, "_done_cycle"}, cyc, RUN_CY);
    check({tag, "_pred_digit"}, pred_digit, exp_pred_digit);
    check({tag, "_pred_score"}, pred_score, exp_pred_score);
    check({tag, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check({tag, "_pred_hold"}, pred_digit, exp_pred_digit);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   cyc, d0;
    q16_t k_neg;
    rst   = 1'b1;
    start = 1'b0;
    load_case(2);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_case("ramp", 0);
    check("ramp_pred9", pred_digit, 9);
    run_case("d3", 1);
    check("d3_pred", pred_digit, 3);
    run_case("tie", 2);
    check("tie_pred", pred_digit, 0);
    run_case("neg", 3);
    k_neg = 32'hFFFB_0000;
    check("neg_pred_score", pred_score, k_neg);
    run_case("rand0", 4);
    run_case("rand1", 4);

    // start held high through a whole run and beyond
    load_case(0);
    push_expected();
    push_expected();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done(cyc);
    check("hold_done_cycle", cyc, RUN_CY);
    @(negedge clk);
    check("hold_idle_busy", busy, 0);
    check("hold_idle_state", dbg_state, S_IDLE);
    @(negedge clk);
    check("hold_restart_busy", busy, 1);
    start = 1'b0;
    wait_done(cyc);
    check("hold_done2_cycle", cyc, RUN_CY);
    check("hold_done_count", done_cnt - d0, 2);
    @(negedge clk);
    check("hold_sb_empty", exp_q.size(), 0);

    // reset in the middle of a run
    load_case(4);
    push_expected();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (400) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle_busy", busy, 0);
    run_case("post_rst", 0);

    check("bias_valid_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
